itoa_writer: RTL and testbench

- Inverse of the string-to-integer path: converts a DSZ-bit integer into an ASCII digit string and writes it byte-by-byte to 8-bit memory starting at a given address, ending with a NUL byte.
- Sits beside the number parser as the bus master for Forth number output (".", "U.", "." in HEX mode).
- Its output strings must parse back to the same value through the parser (lowercase hex, leading '-', NUL terminator).

---
 rtl/itoa_writer.sv | 143 ++++++++++++++
 tb/tb_itoa_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/itoa_writer.sv
// rtl/itoa_writer.sv - integer to NUL-terminated ASCII string writer (signed decimal or unsigned hex)
// Converts vi via double-dabble (decimal) or direct nibble load (hex), then streams bytes to memory.
module itoa_writer #(
    parameter int ASZ = 17,
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           hex,
    input  logic [DSZ-1:0] vi,
    input  logic [ASZ-1:0] ba,
    output logic           bsy,
    output logic           we,
    output logic [ASZ-1:0] ao,
    output logic [7:0]     dout,
    output logic [5:0]     len
);
    localparam int ND = (DSZ * 3 + 9) / 10;
    localparam int BW = 4 * ND;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;
    localparam int CW = $clog2(DSZ + 1);

    typedef enum logic [2:0] {IDLE, CNV, SCAN, SGN, EMIT, TERM} state_t;

    state_t         st_q;
    logic           hex_q;
    logic           neg_q;
    logic [DSZ-1:0] mag_q;
    logic [BW-1:0]  dig_q;
    logic [CW-1:0]  cyc_q;
    logic [IW-1:0]  idx_q;
    logic [5:0]     nlen_q;

    logic [BW-1:0]  adj;
    logic [IW-1:0]  msd;
    logic [IW-1:0]  idx_nxt;

    function automatic logic [7:0] asc(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'd0, d}) : (8'h57 + {4'd0, d});
    endfunction

    // Double-dabble correction applied before each shift.
    always_comb begin
        adj = dig_q;
        for (int i = 0; i < ND; i++) begin
            if (dig_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
        end
    end

    // Highest nonzero digit; an all-zero value leaves msd at 0 so a single '0' is written.
    always_comb begin
        msd = '0;
        for (int i = 0; i < ND; i++) begin
            if (dig_q[4*i +: 4] != 4'd0) msd = IW'(i);
        end
    end

    assign idx_nxt = idx_q - IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            bsy    <= 1'b0;
            we     <= 1'b0;
            ao     <= '0;
            dout   <= '0;
            len    <= '0;
            hex_q  <= 1'b0;
            neg_q  <= 1'b0;
            mag_q  <= '0;
            dig_q  <= '0;
            cyc_q  <= '0;
            idx_q  <= '0;
            nlen_q <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (en) begin
                        hex_q <= hex;
                        ao    <= ba;
                        bsy   <= 1'b1;
                        dig_q <= '0;
                        cyc_q <= CW'(DSZ - 1);
                        st_q  <= CNV;
                        if (!hex && vi[DSZ-1]) begin
                            neg_q <= 1'b1;
                            mag_q <= -vi;
                        end else begin
                            neg_q <= 1'b0;
                            mag_q <= vi;
                        end
                    end
                end
                CNV: begin
                    if (hex_q) begin
                        dig_q <= BW'(mag_q);
                        st_q  <= SCAN;
                    end else begin
                        dig_q <= {adj[BW-2:0], mag_q[DSZ-1]};
                        mag_q <= {mag_q[DSZ-2:0], 1'b0};
                        cyc_q <= cyc_q - CW'(1);
                        if (cyc_q == '0) st_q <= SCAN;
                    end
                end
                SCAN: begin
                    idx_q  <= msd;
                    nlen_q <= 6'(msd) + 6'd1 + {5'd0, neg_q};
                    we     <= 1'b1;
                    if (neg_q) begin
                        dout <= 8'h2d;
                        st_q <= SGN;
                    end else begin
                        dout <= asc(dig_q[{msd, 2'b00} +: 4]);
                        st_q <= EMIT;
                    end
                end
                SGN: begin
                    ao   <= ao + ASZ'(1);
                    dout <= asc(dig_q[{idx_q, 2'b00} +: 4]);
                    st_q <= EMIT;
                end
                EMIT: begin
                    ao <= ao + ASZ'(1);
                    if (idx_q == '0) begin
                        dout <= 8'h00;
                        st_q <= TERM;
                    end else begin
                        idx_q <= idx_nxt;
                        dout  <= asc(dig_q[{idx_nxt, 2'b00} +: 4]);
                    end
                end
                TERM: begin
                    we   <= 1'b0;
                    bsy  <= 1'b0;
                    len  <= nlen_q;
                    st_q <= IDLE;
                end
                default: st_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_itoa_writer.sv
// tb/tb_itoa_writer.sv - directed and round-trip bench for itoa_writer
module tb_itoa_writer;
    localparam int ASZ = 17;
    localparam int DSZ = 32;

    logic           clk = 1'b0;
    logic           rst, en, hex;
    logic [DSZ-1:0] vi;
    logic [ASZ-1:0] ba;
    logic           bsy, we;
    logic [ASZ-1:0] ao;
    logic [7:0]     dout;
    logic [5:0]     len;

    int checks = 0;
    int errors = 0;

    logic [7:0]     wd [0:31];
    logic [ASZ-1:0] wa [0:31];
    int             wk [0:31];
    int             nw, bsy_cyc, lat;

    itoa_writer #(.ASZ(ASZ), .DSZ(DSZ)) dut (
        .clk(clk), .rst(rst), .en(en), .hex(hex), .vi(vi), .ba(ba),
        .bsy(bsy), .we(we), .ao(ao), .dout(dout), .len(len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start one conversion and capture every write until bsy drops.
    task automatic run(input logic h, input logic [DSZ-1:0] v, input logic [ASZ-1:0] b, input logic tog);
        bit done;
        @(negedge clk);
        en = 1'b1; hex = h; vi = v; ba = b;
        @(posedge clk);
        nw = 0; bsy_cyc = 0; lat = -1; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bsy) bsy_cyc++;
            if (we && nw < 32) begin
                if (lat < 0) lat = k;
                wd[nw] = dout; wa[nw] = ao; wk[nw] = k;
                nw++;
            end
            if (!bsy) begin
                en = 1'b0;
                done = 1;
            end else begin
                en = tog ? 1'($urandom_range(1)) : 1'b0;
            end
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
    endtask

    task automatic verify(input string tag, input string s, input logic h, input logic [ASZ-1:0] b);
        int conv;
        logic [7:0] e;
        logic [ASZ-1:0] ea;
        conv = h ? 1 : DSZ;
        chk({tag, " count"}, nw, s.len() + 1);
        for (int i = 0; i <= s.len() && i < nw; i++) begin
            e  = (i < s.len()) ? s[i] : 8'h00;
            ea = b + ASZ'(i);
            chk($sformatf("%s byte%0d", tag, i), wd[i], e);
            chk($sformatf("%s addr%0d", tag, i), wa[i], ea);
            if (i > 0) chk($sformatf("%s gap%0d", tag, i), wk[i], wk[0] + i);
        end
        chk({tag, " latency"}, lat, conv + 1);
        chk({tag, " len"}, len, s.len());
        chk({tag, " bsy_cycles"}, bsy_cyc, conv + 1 + s.len() + 1);
    endtask

    function automatic logic [31:0] parse(input logic h);
        logic [31:0] acc;
        bit ng;
        acc = 0; ng = 0;
        for (int i = 0; i < nw && wd[i] != 8'h00; i++) begin
            if (wd[i] == 8'h2d) ng = 1;
            else if (h) acc = acc * 16 + ((wd[i] >= 8'h61) ? 32'(wd[i] - 8'h57) : 32'(wd[i] - 8'h30));
            else acc = acc * 10 + 32'(wd[i] - 8'h30);
        end
        return ng ? -acc : acc;
    endfunction

    initial begin
        logic [DSZ-1:0] rv;
        logic rh;
        string rs;

        rst = 1'b1; en = 1'b0; hex = 1'b0; vi = '0; ba = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst bsy", bsy, 0);
        chk("rst we", we, 0);
        chk("rst ao", ao, 0);
        chk("rst dout", dout, 0);
        chk("rst len", len, 0);
        rst = 1'b0;

        run(1'b0, 32'd12345, 17'h100, 1'b0);
        verify("dec12345", "12345", 1'b0, 17'h100);
        repeat (3) @(negedge clk);
        chk("hold ao", ao, 17'h105);
        chk("hold len", len, 5);
        chk("hold we", we, 0);

        run(1'b0, 32'h80000000, 17'h200, 1'b0);
        verify("decmin", "-2147483648", 1'b0, 17'h200);

        run(1'b1, 32'h0, 17'h040, 1'b0);
        verify("hex0", "0", 1'b1, 17'h040);
        run(1'b1, 32'hDEADBEEF, 17'h050, 1'b0);
        verify("hexdead", "deadbeef", 1'b1, 17'h050);
        run(1'b1, 32'h80000000, 17'h060, 1'b0);
        verify("hexsign", "80000000", 1'b1, 17'h060);

        run(1'b0, 32'h0, 17'h070, 1'b0);
        verify("dec0", "0", 1'b0, 17'h070);
        run(1'b0, 32'hFFFFFFFF, 17'h080, 1'b0);
        verify("decm1", "-1", 1'b0, 17'h080);

        run(1'b0, 32'd12345, 17'h1FFFE, 1'b0);
        verify("wrap", "12345", 1'b0, 17'h1FFFE);

        run(1'b0, 32'd987654321, 17'h090, 1'b1);
        verify("entoggle", "987654321", 1'b0, 17'h090);

        // Abort in the middle of the digit stream.
        @(negedge clk);
        en = 1'b1; hex = 1'b0; vi = 32'd9876543; ba = 17'h300;
        @(negedge clk);
        en = 1'b0;
        nw = 0;
        for (int k = 0; k < 100 && nw < 3; k++) begin
            @(negedge clk);
            if (we) nw++;
        end
        chk("abort reach", nw, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort we", we, 0);
        chk("abort bsy", bsy, 0);
        chk("abort len", len, 0);
        chk("abort ao", ao, 0);
        @(negedge clk);
        rst = 1'b0;
        nw = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (we || bsy) nw++;
        end
        chk("abort quiet", nw, 0);
        run(1'b0, 32'd9876543, 17'h300, 1'b0);
        verify("restart", "9876543", 1'b0, 17'h300);

        // en held high: one idle cycle, then a fresh accept.
        @(negedge clk);
        en = 1'b1; hex = 1'b1; vi = 32'h0; ba = 17'h400;
        nw = 0;
        for (int k = 0; k < 50 && !bsy; k++) @(negedge clk);
        for (int k = 0; k < 50 && bsy; k++) @(negedge clk);
        chk("held idle", bsy, 0);
        @(negedge clk);
        chk("held reaccept", bsy, 1);
        en = 1'b0;
        for (int k = 0; k < 50 && bsy; k++) @(negedge clk);
        chk("held drain", bsy, 0);

        for (int i = 0; i < 4; i++) begin
            rv = $urandom;
            rh = 1'(i % 2);
            rs = rh ? $sformatf("%0h", rv) : $sformatf("%0d", $signed(rv));
            run(rh, rv, 17'(17'h500 + 17'(i * 32)), 1'b0);
            verify($sformatf("rand%0d", i), rs, rh, 17'(17'h500 + 17'(i * 32)));
            chk($sformatf("roundtrip%0d", i), parse(rh), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
